// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter: N_REQ valid/ready producers share one Fifo write port.
// Grant takes 1 cycle from valid; writes are combinational in BURST; ready drops while the Fifo is at its limit.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter int DEPTH     = 64,
  parameter int HEADROOM  = 0,
  parameter int BURST_LEN = 8,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_buf_in,
  input  logic                      fifo_full,
  input  logic [CNT_W-1:0]          fifo_counter,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic [15:0]               words_total
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
  localparam int                LIMIT     = DEPTH - HEADROOM;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   owner, owner_nxt;
  logic [ID_W-1:0]   last_grant, last_grant_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic              throttle;
  logic              active;
  logic              owner_valid;
  logic              xfer;

  assign throttle    = fifo_full | (int'(fifo_counter) >= LIMIT);
  // Outputs are held quiet while rst is high so a word presented mid-reset is never written.
  assign active      = (state == BURST) & ~rst;
  assign owner_valid = req_valid[owner];
  assign xfer        = active & owner_valid & ~throttle;

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant) + k) % N_REQ]) begin
        pick     = ID_W'((int'(last_grant) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt      = BURST;
          owner_nxt      = pick;
          last_grant_nxt = pick;
          beat_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (!owner_valid) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (active) begin
      req_ready[owner] = ~throttle;
    end
    fifo_wr_en  = xfer;
    fifo_buf_in = active ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
    grant_valid = active;
    grant_id    = owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_grant  <= LAST_ID;
      beat_cnt    <= '0;
      words_total <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      if (xfer) begin
        words_total <= words_total + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a behavioural Fifo occupancy model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_buf_in;
  logic            fifo_full = 1'b0;
  logic [7:0]      fifo_counter = '0;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [15:0]     words_total;

  logic [N-1:0]    h_valid = '0;
  logic [N*DW-1:0] h_data  = '0;
  logic [N-1:0]    h_ready;
  logic            h_wr;
  logic [DW-1:0]   h_buf;
  logic            h_full = 1'b0;
  logic [7:0]      h_cnt  = 8'd60;
  logic            h_gv;
  logic [1:0]      h_gid;
  logic [15:0]     h_total;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(8), .DEPTH(64), .HEADROOM(0), .BURST_LEN(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_buf_in(fifo_buf_in), .fifo_full(fifo_full),
    .fifo_counter(fifo_counter), .grant_valid(grant_valid), .grant_id(grant_id),
    .words_total(words_total));

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(8), .DEPTH(64), .HEADROOM(4), .BURST_LEN(8)) dut_hr (
    .clk(clk), .rst(rst), .req_valid(h_valid), .req_data(h_data), .req_ready(h_ready),
    .fifo_wr_en(h_wr), .fifo_buf_in(h_buf), .fifo_full(h_full),
    .fifo_counter(h_cnt), .grant_valid(h_gv), .grant_id(h_gid), .words_total(h_total));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] prod_q [N][$];
  logic [7:0] exp_q  [N][$];
  int         wr_cyc [$];
  int         gnt_log[$];
  int         gnt_tot[$];
  int         fifo_cnt = 0;
  int         cyc = 0;
  int         nwr = 0;
  int         ovf = 0;
  logic       rd_en = 1'b0;
  logic [N-1:0] acc_l = '0;
  logic       wr_l = 1'b0;
  logic       rd_l = 1'b0;
  logic       gv_prev = 1'b0;

  // Producers and Fifo occupancy advance just after each edge using what was seen mid-cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_l[i]) void'(prod_q[i].pop_front());
    end
    if (rst) fifo_cnt = 0;
    else     fifo_cnt = fifo_cnt + int'(wr_l) - int'(rd_l);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (prod_q[i].size() > 0);
      req_data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : 8'h00;
    end
    fifo_full    = (fifo_cnt >= 64);
    fifo_counter = fifo_cnt[7:0];
  end

  always @(negedge clk) begin
    acc_l = req_valid & req_ready;
    wr_l  = fifo_wr_en;
    rd_l  = rd_en && (fifo_cnt > 0);
    if (fifo_wr_en) begin
      if (fifo_full) ovf++;
      nwr++;
      wr_cyc.push_back(cyc);
      check("sb_nonempty", 32'(exp_q[grant_id].size() != 0), 32'd1);
      if (exp_q[grant_id].size() != 0) check("sb_data", 32'(fifo_buf_in), 32'(exp_q[grant_id].pop_front()));
    end
    if (grant_valid && !gv_prev) begin
      gnt_log.push_back(int'(grant_id));
      gnt_tot.push_back(int'(words_total));
    end
    gv_prev = grant_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int i, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      prod_q[i].push_back(8'(base + k));
      exp_q[i].push_back(8'(base + k));
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    logic busy;
    t = 0;
    busy = 1'b1;
    while (busy && t < budget) begin
      tick();
      t++;
      busy = grant_valid;
      for (int i = 0; i < N; i++) if (prod_q[i].size() != 0) busy = 1'b1;
    end
    check("drain_in_budget", 32'(t < budget), 32'd1);
  endtask

  initial begin
    int gb, wb, nb, t;
    int ord2[5];
    ord2 = '{0, 1, 2, 3, 0};

    // 1: reset state, single producer streaming 10 words
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_gv", 32'(grant_valid), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_buf", 32'(fifo_buf_in), 32'd0);
    check("rst_total", 32'(words_total), 32'd0);
    gb = gnt_log.size(); wb = wr_cyc.size(); nb = nwr;
    load(0, 0, 10);
    wait_drain(100);
    check("t1_nwr", 32'(nwr - nb), 32'd10);
    check("t1_ngnt", 32'(gnt_log.size() - gb), 32'd2);
    check("t1_gnt0", 32'(gnt_log[gb]), 32'd0);
    check("t1_gnt1", 32'(gnt_log[gb+1]), 32'd0);
    check("t1_burst_span", 32'(wr_cyc[wb+7] - wr_cyc[wb]), 32'd7);
    check("t1_gap", 32'(wr_cyc[wb+8] - wr_cyc[wb+7]), 32'd2);
    check("t1_second", 32'(wr_cyc[wb+9] - wr_cyc[wb+8]), 32'd1);
    check("t1_total", 32'(words_total), 32'd10);

    // 2: all producers requesting, round-robin rotation
    apply_reset(1);
    gb = gnt_log.size(); wb = wr_cyc.size();
    load(0, 8'h10, 16); load(1, 8'h40, 8); load(2, 8'h60, 8); load(3, 8'h80, 8);
    wait_drain(200);
    check("t2_ngnt", 32'(gnt_log.size() - gb), 32'd5);
    for (int k = 0; k < 5; k++) check("t2_order", 32'(gnt_log[gb+k]), 32'(ord2[k]));
    check("t2_total_at_5th", 32'(gnt_tot[gb+4]), 32'd32);
    check("t2_gap", 32'(wr_cyc[wb+8] - wr_cyc[wb+7]), 32'd2);
    check("t2_total", 32'(words_total), 32'd40);

    // 3: fill the Fifo, stall with ownership kept, one read frees one write
    apply_reset(1);
    nb = nwr;
    load(0, 0, 70);
    t = 0;
    while ((nwr - nb) < 64 && t < 200) begin tick(); t++; end
    repeat (10) tick();
    check("t3_fill", 32'(nwr - nb), 32'd64);
    check("t3_full", 32'(fifo_full), 32'd1);
    check("t3_ready", 32'(req_ready), 32'd0);
    check("t3_wr_en", 32'(fifo_wr_en), 32'd0);
    check("t3_gv", 32'(grant_valid), 32'd1);
    check("t3_gid", 32'(grant_id), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (6) tick();
    check("t3_one_more", 32'(nwr - nb), 32'd65);
    check("t3_cnt", 32'(fifo_counter), 32'd64);
    rd_en = 1'b1;
    wait_drain(300);
    rd_en = 1'b0;
    check("t3_all", 32'(nwr - nb), 32'd70);
    check("t3_no_overflow", 32'(ovf), 32'd0);

    // 4: HEADROOM=4 build throttles at counter 60
    h_data[DW-1:0] = 8'hA5;
    h_valid = 4'b0001;
    tick(); tick(); tick();
    check("t4_gv", 32'(h_gv), 32'd1);
    check("t4_ready60", 32'(h_ready), 32'd0);
    check("t4_wr60", 32'(h_wr), 32'd0);
    h_cnt = 8'd63; #1;
    check("t4_ready63", 32'(h_ready), 32'd0);
    h_cnt = 8'd59; #1;
    check("t4_ready59", 32'(h_ready), 32'd1);
    check("t4_wr59", 32'(h_wr), 32'd1);
    check("t4_buf59", 32'(h_buf), 32'hA5);
    tick();
    h_cnt = 8'd60; #1;
    check("t4_ready_back60", 32'(h_ready), 32'd0);
    check("t4_total", 32'(h_total), 32'd1);
    h_cnt = 8'd10; h_full = 1'b1; #1;
    check("t4_ready_full", 32'(h_ready), 32'd0);
    h_valid = '0;

    // 5: owner drops valid early, next requester wins even if the first re-requests
    apply_reset(1);
    gb = gnt_log.size(); nb = nwr;
    load(2, 8'h20, 3); load(3, 8'h30, 4);
    t = 0;
    while (prod_q[2].size() != 0 && t < 50) begin tick(); t++; end
    check("t5_hold_gv", 32'(grant_valid), 32'd1);
    check("t5_hold_gid", 32'(grant_id), 32'd2);
    load(2, 8'h28, 2);
    tick();
    check("t5_idle", 32'(grant_valid), 32'd0);
    wait_drain(100);
    check("t5_ngnt", 32'(gnt_log.size() - gb), 32'd3);
    check("t5_gnt0", 32'(gnt_log[gb]), 32'd2);
    check("t5_gnt1", 32'(gnt_log[gb+1]), 32'd3);
    check("t5_gnt2", 32'(gnt_log[gb+2]), 32'd2);
    check("t5_nwr", 32'(nwr - nb), 32'd9);

    // 6: reset mid-burst at beat 5
    apply_reset(1);
    nb = nwr;
    load(1, 8'h50, 8);
    t = 0;
    while ((nwr - nb) < 5 && t < 50) begin tick(); t++; end
    check("t6_pre_wr", 32'(fifo_wr_en), 32'd1);
    check("t6_pre_buf", 32'(fifo_buf_in), 32'h55);
    rst = 1'b1; #1;
    check("t6_rst_nowrite", 32'(fifo_wr_en), 32'd0);
    load(0, 8'h70, 2); load(3, 8'h90, 2);
    tick();
    rst = 1'b0; #1;
    check("t6_gv", 32'(grant_valid), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd0);
    check("t6_total", 32'(words_total), 32'd0);
    gb = gnt_log.size(); nb = nwr;
    wait_drain(100);
    check("t6_gnt0", 32'(gnt_log[gb]), 32'd0);
    check("t6_gnt1", 32'(gnt_log[gb+1]), 32'd1);
    check("t6_gnt2", 32'(gnt_log[gb+2]), 32'd3);
    check("t6_nwr", 32'(nwr - nb), 32'd7);
    check("t6_total_after", 32'(words_total), 32'd7);
    for (int i = 0; i < N; i++) check("sb_leftover", 32'(exp_q[i].size()), 32'd0);
    check("no_overflow", 32'(ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
